// File: rtl/block_downscaler.sv
// Block downscaler: walks a source frame in FACTOR x FACTOR blocks and streams one pixel per block.
// BLOCK_DOWNSCALER_AVG_EN selects box-filter averaging; when it is undefined the block is nearest-neighbour.
module block_downscaler #(
    parameter int SRC_W  = 320,
    parameter int SRC_H  = 240,
    parameter int FACTOR = 2,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 17,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_q,
    output logic [PIX_W-1:0]  pix_out,
    output logic [ADDR_W-1:0] pix_index,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              busy,
    output logic              done
);

    localparam int L     = $clog2(FACTOR);
    localparam int OUT_W = SRC_W / FACTOR;
    localparam int OUT_H = SRC_H / FACTOR;
    localparam int NPIX  = OUT_W * OUT_H;
`ifdef BLOCK_DOWNSCALER_AVG_EN
    localparam int NREADS = FACTOR * FACTOR;
    localparam int ACC_W  = PIX_W + 2 * L;
`else
    localparam int NREADS = 1;
`endif
    localparam int CW = 2 * L + 1;

    localparam logic [CW-1:0]     LAST_RD    = CW'(NREADS - 1);
    localparam logic [L-1:0]      LAST_COL   = L'(FACTOR - 1);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(SRC_W);
    localparam logic [ADDR_W-1:0] BLK_STEP   = ADDR_W'(FACTOR);
    // Jump from the last block of a band to the first block of the next band.
    localparam logic [ADDR_W-1:0] BAND_STEP  = ADDR_W'((FACTOR - 1) * SRC_W + FACTOR);
    localparam logic [ADDR_W-1:0] LAST_OX    = ADDR_W'(OUT_W - 1);
    localparam logic [ADDR_W-1:0] LAST_PIX   = ADDR_W'(NPIX - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_OUT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       issCnt_q, issCnt_d;
    logic [CW-1:0]       rcvCnt_q, rcvCnt_d;
    logic [L-1:0]        col_q, col_d;
    logic [ADDR_W-1:0]   rowAddr_q, rowAddr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   blkBase_q, blkBase_d;
    logic [ADDR_W-1:0]   ox_q, ox_d;
    logic [ADDR_W-1:0]   k_q, k_d;
    logic [PIX_W-1:0]    pixOut_q, pixOut_d;
    logic [RD_LAT-1:0]   rdPipe_q, rdPipe_d;
    logic [ADDR_W-1:0]   nextBase;
    logic                dataVld;
`ifdef BLOCK_DOWNSCALER_AVG_EN
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    accSum;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            issCnt_q  <= '0;
            rcvCnt_q  <= '0;
            col_q     <= '0;
            rowAddr_q <= '0;
            addr_q    <= '0;
            blkBase_q <= '0;
            ox_q      <= '0;
            k_q       <= '0;
            pixOut_q  <= '0;
            rdPipe_q  <= '0;
`ifdef BLOCK_DOWNSCALER_AVG_EN
            acc_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            issCnt_q  <= issCnt_d;
            rcvCnt_q  <= rcvCnt_d;
            col_q     <= col_d;
            rowAddr_q <= rowAddr_d;
            addr_q    <= addr_d;
            blkBase_q <= blkBase_d;
            ox_q      <= ox_d;
            k_q       <= k_d;
            pixOut_q  <= pixOut_d;
            rdPipe_q  <= rdPipe_d;
`ifdef BLOCK_DOWNSCALER_AVG_EN
            acc_q     <= acc_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        issCnt_d  = issCnt_q;
        rcvCnt_d  = rcvCnt_q;
        col_d     = col_q;
        rowAddr_d = rowAddr_q;
        addr_d    = addr_q;
        blkBase_d = blkBase_q;
        ox_d      = ox_q;
        k_d       = k_q;
        pixOut_d  = pixOut_q;
        nextBase  = blkBase_q;
        rdPipe_d  = '0;
`ifdef BLOCK_DOWNSCALER_AVG_EN
        acc_d     = acc_q;
        accSum    = acc_q + ACC_W'(mem_q);
`endif

        // Read strobes travel down this pipe so each datum is caught exactly RD_LAT cycles later.
        rdPipe_d[0] = (state_q == S_FETCH);
        for (int i = 1; i < RD_LAT; i++) begin
            rdPipe_d[i] = rdPipe_q[i-1];
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_FETCH;
                    issCnt_d  = '0;
                    rcvCnt_d  = '0;
                    col_d     = '0;
                    rowAddr_d = '0;
                    addr_d    = '0;
                    blkBase_d = '0;
                    ox_d      = '0;
                    k_d       = '0;
                end
            end
            S_FETCH: begin
                issCnt_d = issCnt_q + CW'(1);
                if (col_q == LAST_COL) begin
                    col_d     = '0;
                    rowAddr_d = rowAddr_q + ROW_STRIDE;
                    addr_d    = rowAddr_q + ROW_STRIDE;
                end else begin
                    col_d  = col_q + L'(1);
                    addr_d = addr_q + ADDR_W'(1);
                end
                if (issCnt_q == LAST_RD) begin
                    state_d = S_DRAIN;
                end
            end
            S_OUT: begin
                if (pix_ready) begin
                    k_d = k_q + ADDR_W'(1);
                    if (k_q == LAST_PIX) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                        if (ox_q == LAST_OX) begin
                            ox_d     = '0;
                            nextBase = blkBase_q + BAND_STEP;
                        end else begin
                            ox_d     = ox_q + ADDR_W'(1);
                            nextBase = blkBase_q + BLK_STEP;
                        end
                        blkBase_d = nextBase;
                        rowAddr_d = nextBase;
                        addr_d    = nextBase;
                        col_d     = '0;
                        issCnt_d  = '0;
                        rcvCnt_d  = '0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = state_q;
            end
        endcase

        dataVld = rdPipe_q[RD_LAT-1] && ((state_q == S_FETCH) || (state_q == S_DRAIN));
        if (dataVld) begin
            rcvCnt_d = rcvCnt_q + CW'(1);
`ifdef BLOCK_DOWNSCALER_AVG_EN
            acc_d = accSum;
            if (rcvCnt_q == LAST_RD) begin
                pixOut_d = PIX_W'(accSum >> (2 * L));
                state_d  = S_OUT;
            end
`else
            if (rcvCnt_q == LAST_RD) begin
                pixOut_d = mem_q;
                state_d  = S_OUT;
            end
`endif
        end

`ifdef BLOCK_DOWNSCALER_AVG_EN
        if ((state_d == S_FETCH) && (state_q != S_FETCH)) begin
            acc_d = '0;
        end
`endif
    end

    assign mem_rd    = (state_q == S_FETCH);
    assign mem_addr  = addr_q;
    assign pix_out   = pixOut_q;
    assign pix_index = k_q;
    assign pix_valid = (state_q == S_OUT);
    assign busy      = (state_q == S_FETCH) || (state_q == S_DRAIN) || (state_q == S_OUT);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_block_downscaler.sv
// Self-checking bench for block_downscaler on an 8x4 frame, FACTOR=2, with RD_LAT=1 and RD_LAT=3 instances.
// Expected pixels come from a direct block-sum model over the bench's memory array.
module tb_block_downscaler;

    localparam int SRC_W  = 8;
    localparam int SRC_H  = 4;
    localparam int FACTOR = 2;
    localparam int PIX_W  = 8;
    localparam int ADDR_W = 17;
    localparam int OUT_W  = SRC_W / FACTOR;
    localparam int NPIX   = OUT_W * (SRC_H / FACTOR);
`ifdef BLOCK_DOWNSCALER_AVG_EN
    localparam int NRD = FACTOR * FACTOR;
`else
    localparam int NRD = 1;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              pix_ready = 1'b1;
    logic              mem_rd, pix_valid, busy, done;
    logic [ADDR_W-1:0] mem_addr, pix_index;
    logic [PIX_W-1:0]  mem_q, pix_out;

    logic              start3 = 1'b0;
    logic              pix_ready3 = 1'b1;
    logic              mem_rd3, pix_valid3, busy3, done3;
    logic [ADDR_W-1:0] mem_addr3, pix_index3;
    logic [PIX_W-1:0]  mem_q3, pix_out3;

    logic [7:0] mem [0:31];
    logic [7:0] p1, q3a, q3b, q3c;

    int testsRun;
    int testsFailed;

    always #5 clk = ~clk;

    block_downscaler #(
        .SRC_W(SRC_W), .SRC_H(SRC_H), .FACTOR(FACTOR),
        .PIX_W(PIX_W), .ADDR_W(ADDR_W), .RD_LAT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_q(mem_q),
        .pix_out(pix_out), .pix_index(pix_index), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .busy(busy), .done(done)
    );

    block_downscaler #(
        .SRC_W(SRC_W), .SRC_H(SRC_H), .FACTOR(FACTOR),
        .PIX_W(PIX_W), .ADDR_W(ADDR_W), .RD_LAT(3)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3),
        .mem_rd(mem_rd3), .mem_addr(mem_addr3), .mem_q(mem_q3),
        .pix_out(pix_out3), .pix_index(pix_index3), .pix_valid(pix_valid3),
        .pix_ready(pix_ready3), .busy(busy3), .done(done3)
    );

    // RAM models: one-cycle and three-cycle read latency.
    always @(posedge clk) p1 <= mem[mem_addr[4:0]];
    always @(posedge clk) begin
        q3a <= mem[mem_addr3[4:0]];
        q3b <= q3a;
        q3c <= q3b;
    end
    assign mem_q  = p1;
    assign mem_q3 = q3c;

    int cycle = 0;
    int outQ[$];
    int idxQ[$];
    int addrQ[$];
    int doneCount, busyWithDone, doneCycle, lastXferCycle;
    int outQ3[$];
    int doneCount3, rdCount3;

    always @(negedge clk) begin
        cycle++;
        if (pix_valid && pix_ready) begin
            outQ.push_back(int'(pix_out));
            idxQ.push_back(int'(pix_index));
            lastXferCycle = cycle;
        end
        if (mem_rd) addrQ.push_back(int'(mem_addr));
        if (done) begin
            doneCount++;
            doneCycle = cycle;
            if (busy) busyWithDone++;
        end
        if (pix_valid3 && pix_ready3) outQ3.push_back(int'(pix_out3));
        if (mem_rd3) rdCount3++;
        if (done3) doneCount3++;
    end

    function automatic int blockBase(input int k);
        return (k / OUT_W) * FACTOR * SRC_W + (k % OUT_W) * FACTOR;
    endfunction

    function automatic int refPix(input int k);
        int sum;
        sum = 0;
`ifdef BLOCK_DOWNSCALER_AVG_EN
        for (int r = 0; r < FACTOR; r++)
            for (int c = 0; c < FACTOR; c++)
                sum += int'(mem[blockBase(k) + r * SRC_W + c]);
        return sum / (FACTOR * FACTOR);
`else
        sum = int'(mem[blockBase(k)]);
        return sum;
`endif
    endfunction

    task automatic clearMon();
        outQ.delete();
        idxQ.delete();
        addrQ.delete();
        outQ3.delete();
        doneCount = 0;
        busyWithDone = 0;
        doneCycle = -1;
        lastXferCycle = -1;
        doneCount3 = 0;
        rdCount3 = 0;
    endtask

    task automatic randomizeMem();
        for (int a = 0; a < 32; a++) mem[a] = 8'($urandom_range(0, 255));
    endtask

    task automatic startPulse(input string name);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        testsRun++;
        if (busy !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL %s_busy_rise: got %b expected 1", name, busy);
        end
    endtask

    task automatic measureLat(input string name, input int expected);
        int cnt;
        cnt = 0;
        while (pix_valid !== 1'b1 && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        testsRun++;
        if (cnt != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d cycles expected %0d", name, cnt, expected);
        end
    endtask

    task automatic waitDone(input string name);
        int cnt;
        cnt = 0;
        while (doneCount == 0 && cnt < 500) begin
            @(posedge clk); #1;
            cnt++;
        end
        testsRun++;
        if (doneCount == 0) begin
            testsFailed++;
            $display("[TB] FAIL %s_timeout: got no done expected done within 500 cycles", name);
        end else if (busy !== 1'b0 || done !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL %s_idle_after_done: got busy=%b done=%b expected 0 0", name, busy, done);
        end
    endtask

    task automatic checkFrame(input string name);
        int expAddr[$];
        testsRun++;
        if (outQ.size() != NPIX) begin
            testsFailed++;
            $display("[TB] FAIL %s_count: got %0d pixels expected %0d", name, outQ.size(), NPIX);
        end
        for (int k = 0; k < outQ.size() && k < NPIX; k++) begin
            testsRun++;
            if (outQ[k] != refPix(k) || idxQ[k] != k) begin
                testsFailed++;
                $display("[TB] FAIL %s_pix%0d: got value %0d index %0d expected value %0d index %0d",
                         name, k, outQ[k], idxQ[k], refPix(k), k);
            end
        end
        for (int k = 0; k < NPIX; k++)
            for (int r = 0; r < FACTOR; r++)
                for (int c = 0; c < FACTOR; c++)
                    if (NRD > 1 || (r == 0 && c == 0))
                        expAddr.push_back(blockBase(k) + r * SRC_W + c);
        testsRun++;
        if (addrQ.size() != expAddr.size()) begin
            testsFailed++;
            $display("[TB] FAIL %s_read_count: got %0d reads expected %0d", name, addrQ.size(), expAddr.size());
        end else begin
            for (int i = 0; i < expAddr.size(); i++) begin
                testsRun++;
                if (addrQ[i] != expAddr[i]) begin
                    testsFailed++;
                    $display("[TB] FAIL %s_addr%0d: got %0d expected %0d", name, i, addrQ[i], expAddr[i]);
                end
            end
        end
        testsRun++;
        if (doneCount != 1 || busyWithDone != 0 || doneCycle != lastXferCycle + 1) begin
            testsFailed++;
            $display("[TB] FAIL %s_done: got count=%0d busyWithDone=%0d gap=%0d expected 1 0 1",
                     name, doneCount, busyWithDone, doneCycle - lastXferCycle);
        end
    endtask

    task automatic checkOutputsZero(input string name);
        testsRun++;
        if (mem_rd !== 1'b0 || mem_addr !== '0 || pix_out !== '0 || pix_index !== '0 ||
            pix_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL %s: got rd=%b addr=%0d pix=%0d idx=%0d vld=%b busy=%b done=%b expected all 0",
                     name, mem_rd, mem_addr, pix_out, pix_index, pix_valid, busy, done);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checkOutputsZero("reset_values");
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutputsZero("idle_after_reset");
    endtask

    task automatic test_ramp_frame();
        int rampExp[8];
`ifdef BLOCK_DOWNSCALER_AVG_EN
        rampExp = '{4, 6, 8, 10, 20, 22, 24, 26};
`else
        rampExp = '{0, 2, 4, 6, 16, 18, 20, 22};
`endif
        for (int a = 0; a < 32; a++) mem[a] = 8'(a);
        clearMon();
        startPulse("ramp");
        measureLat("ramp_latency", NRD + 1);
        waitDone("ramp");
        for (int k = 0; k < NPIX; k++) begin
            testsRun++;
            if (k >= outQ.size() || outQ[k] != rampExp[k]) begin
                testsFailed++;
                $display("[TB] FAIL ramp_pix%0d: got %0d expected %0d", k,
                         (k < outQ.size()) ? outQ[k] : -1, rampExp[k]);
            end
        end
        checkFrame("ramp");
    endtask

    task automatic test_random_frame();
        randomizeMem();
        clearMon();
        startPulse("random");
        measureLat("random_latency", NRD + 1);
        waitDone("random");
        checkFrame("random");
    endtask

    task automatic test_back_to_back();
        randomizeMem();
        clearMon();
        startPulse("b2b");
        waitDone("b2b");
        checkFrame("b2b");
    endtask

    task automatic test_backpressure();
        int cnt;
        randomizeMem();
        clearMon();
        startPulse("bp");
        cnt = 0;
        while (!(pix_valid === 1'b1 && pix_index == 2) && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        pix_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            testsRun++;
            if (pix_valid !== 1'b1 || int'(pix_out) != refPix(2) || pix_index != 2 || mem_rd !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL bp_stall%0d: got vld=%b pix=%0d idx=%0d rd=%b expected 1 %0d 2 0",
                         i, pix_valid, pix_out, pix_index, mem_rd, refPix(2));
            end
        end
        testsRun++;
        if (outQ.size() != 2) begin
            testsFailed++;
            $display("[TB] FAIL bp_no_xfer: got %0d transfers expected 2", outQ.size());
        end
        pix_ready = 1'b1;
        waitDone("bp");
        checkFrame("bp");
    endtask

    task automatic test_reset_midframe();
        int cnt;
        randomizeMem();
        clearMon();
        startPulse("abort");
        cnt = 0;
        while (!(outQ.size() == 3 && mem_rd === 1'b1) && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        testsRun++;
        if (cnt >= 200) begin
            testsFailed++;
            $display("[TB] FAIL abort_reach_fetch3: got timeout expected FETCH of pixel 3");
        end
        rst_n = 1'b0;
        #1;
        checkOutputsZero("abort_async");
        @(posedge clk); #1;
        checkOutputsZero("abort_next_cycle");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        testsRun++;
        if (doneCount != 0 || busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL abort_no_done: got done=%0d busy=%b expected 0 0", doneCount, busy);
        end
        clearMon();
        startPulse("restart");
        waitDone("restart");
        testsRun++;
        if (outQ.size() == 0 || outQ[0] != refPix(0) || idxQ[0] != 0) begin
            testsFailed++;
            $display("[TB] FAIL restart_pix0: got value %0d index %0d expected value %0d index 0",
                     (outQ.size() > 0) ? outQ[0] : -1, (idxQ.size() > 0) ? idxQ[0] : -1, refPix(0));
        end
        checkFrame("restart");
    endtask

    task automatic test_start_during_out();
        int cnt;
        randomizeMem();
        clearMon();
        startPulse("stout");
        cnt = 0;
        while (!(pix_valid === 1'b1 && pix_index == 4) && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        pix_ready = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        pix_ready = 1'b1;
        waitDone("stout");
        repeat (10) @(posedge clk);
        #1;
        testsRun++;
        if (busy !== 1'b0 || doneCount != 1) begin
            testsFailed++;
            $display("[TB] FAIL stout_ignored: got busy=%b done=%0d expected 0 1", busy, doneCount);
        end
        checkFrame("stout");
    endtask

    task automatic test_rd_lat3();
        int cnt;
        randomizeMem();
        clearMon();
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        cnt = 0;
        while (pix_valid3 !== 1'b1 && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        testsRun++;
        if (cnt != NRD + 3) begin
            testsFailed++;
            $display("[TB] FAIL lat3_latency: got %0d cycles expected %0d", cnt, NRD + 3);
        end
        cnt = 0;
        while (doneCount3 == 0 && cnt < 600) begin
            @(posedge clk); #1;
            cnt++;
        end
        testsRun++;
        if (doneCount3 != 1 || outQ3.size() != NPIX || rdCount3 != NPIX * NRD || busy3 !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL lat3_frame: got done=%0d pixels=%0d reads=%0d busy=%b expected 1 %0d %0d 0",
                     doneCount3, outQ3.size(), rdCount3, busy3, NPIX, NPIX * NRD);
        end
        for (int k = 0; k < outQ3.size() && k < NPIX; k++) begin
            testsRun++;
            if (outQ3[k] != refPix(k)) begin
                testsFailed++;
                $display("[TB] FAIL lat3_pix%0d: got %0d expected %0d", k, outQ3[k], refPix(k));
            end
        end
    endtask

    initial begin
        testsRun = 0;
        testsFailed = 0;
        clearMon();
        randomizeMem();
        test_reset();
        test_ramp_frame();
        test_random_frame();
        test_back_to_back();
        test_backpressure();
        test_reset_midframe();
        test_start_during_out();
        test_rd_lat3();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/block_downscaler.md
# block_downscaler

Parametrised frame downscaler that walks a source frame buffer in FACTOR×FACTOR pixel blocks and emits one output pixel per block over a valid/ready stream. It sits between the frame-buffer RAM read port and the display/transmit path. It adds:
- configurable source geometry, block factor, pixel width and RAM read latency;
- box-filter averaging;
- output backpressure;
- an incremental (multiplier-free) address generator.

## Interface
- SRC_W, 320: source frame width in pixels; must be a multiple of FACTOR.
- SRC_H, 240: source frame height in pixels; must be a multiple of FACTOR.
- FACTOR, 2: block edge length; legal values 2 or 4. Let L = log2(FACTOR).
- PIX_W, 8: pixel width in bits.
- ADDR_W, 17: RAM address width; must satisfy 2^ADDR_W ≥ SRC_W·SRC_H.
- RD_LAT, 1: RAM read latency in cycles, 1..3. mem_q is valid RD_LAT cycles after the cycle in which mem_rd=1.
- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a frame; sampled only in IDLE.
- mem_rd  output  1  RAM read strobe.
- mem_addr  output  ADDR_W  RAM read address.
- mem_q  input  PIX_W  RAM read data.
- pix_out  output  PIX_W  downscaled pixel.
- pix_index  output  ADDR_W  raster index of pix_out in the output frame.
- pix_valid  output  1  pix_out and pix_index are valid.
- pix_ready  input  1  sink accepts the pixel.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse after the last pixel transfers.

## Operation
- OUT_W = SRC_W/FACTOR, OUT_H = SRC_H/FACTOR, N = FACTOR².
- States and transitions:
  - IDLE → FETCH on start.
  - FETCH: issues N reads, one per cycle, mem_rd=1. → DRAIN.
  - DRAIN: waits for the outstanding read data. → OUT when the last datum has been accumulated.
  - OUT: holds pix_valid=1. On transfer → FETCH for the next pixel, or → DONE after the last pixel.
  - DONE: lasts one cycle → IDLE.
- Output pixel (ox, oy), k = oy·OUT_W + ox. Sample (r, c), with r, c in 0..FACTOR−1, is read in row-major order from address (oy·FACTOR + r)·SRC_W + ox·FACTOR + c.
- Addresses are formed incrementally from row-base and column registers. No multipliers or dividers are used.
- The accumulator is PIX_W+2L bits wide and is cleared on FETCH entry. pix_out = acc >> 2L (truncating, no rounding).
- pix_index = k. It wraps to 0 at frame start.
- Transfer occurs when pix_valid && pix_ready are both high at a rising edge. pix_out and pix_index stay stable while pix_valid=1 and pix_ready=0.
- No reads are issued in OUT; mem_rd=0 outside FETCH.
- start is ignored in FETCH, DRAIN, OUT and DONE.
- Reset values: all outputs 0 (mem_rd, mem_addr, pix_out, pix_index, pix_valid, busy, done), state IDLE, accumulator 0.
- Reset asserted mid-frame aborts the frame immediately. No done is produced, and in-flight read data is discarded.

## Timing
- busy rises the cycle after start is sampled in IDLE. It falls in the same cycle that done rises.
- FETCH entry is the cycle after start, or the cycle after a transfer.
- pix_valid rises exactly N + RD_LAT cycles after FETCH entry. For FACTOR=2, RD_LAT=1 this is 5 cycles.
- With pix_ready held high, throughput is one pixel per N+RD_LAT+1 cycles.
- done is high for exactly one cycle, the cycle after the transfer of pixel OUT_W·OUT_H−1. The earliest new start accepted is in the following cycle (IDLE).

## Configuration
- Macro: BLOCK_DOWNSCALER_AVG_EN.
- Defined: box-filter averaging as described above. N reads are issued per output pixel.
- Undefined: nearest-neighbour mode.
  - One read per output pixel, at sample (0,0) of the block.
  - pix_out = mem_q directly; no accumulator is built.
  - pix_valid rises 1 + RD_LAT cycles after FETCH entry.
  - All other behaviour is identical.

## Test plan
- Common setup: SRC_W=8, SRC_H=4, FACTOR=2, RD_LAT=1, mem[a]=a, pix_ready=1.
  - AVG_EN, frame run → pixels 0..7 = 4, 6, 8, 10, 20, 22, 24, 26.
  - First pixel reads addresses 0, 1, 8, 9.
  - Exactly 8 transfers, then done high for 1 cycle; busy low afterwards.
- Same setup, RD_LAT=3 → pix_valid rises 7 cycles after FETCH entry; pixel values are unchanged.
- Backpressure: hold pix_ready=0 for 5 cycles on pixel 2 → pix_out stays 8, pix_index stays 2, mem_rd stays 0 throughout; pixel 3 = 10 follows the release.
- Nearest mode (macro undefined), same memory → outputs 0, 2, 4, 6, 16, 18, 20, 22; one mem_rd per pixel.
- Assert rst_n=0 during FETCH of pixel 3 → all outputs 0 next cycle, no done. A new start then produces pixel 0 = 4 with pix_index=0.
- Pulse start during OUT → ignored: the frame still yields 8 pixels and a single done.
